// File: rtl/csa_resolver.sv
// csa_resolver: resolves a redundant (sum, carry) pair from the wallace tree
// into a single binary word. A segmented ripple adder handles SEG bits per
// cycle, so an operation takes NSEG = DW/SEG cycles. Both sides use
// valid/ready handshakes.
module csa_resolver #(
   parameter int DW  = 16,
   parameter int SEG = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] sum_i,
   input  logic [DW-1:0] carry_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] result_o,
   output logic          cout_o
);

   localparam int NSEG = DW / SEG;
   localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [DW-1:0] s_q;
   logic [DW-1:0] cy_q;
   logic [DW-1:0] res_q;
   logic [CW-1:0] cnt_q;
   logic          c_q;
   logic          cout_q;
   logic          accept;
   logic [SEG:0]  seg_sum;

   // State register; reset discards any in-flight operation.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state and handshake outputs; only IDLE accepts, only DONE presents.
   always_comb begin
      state_next = state;
      ready_o    = 1'b0;
      valid_o    = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == LAST) state_next = DONE;
         end
         DONE: begin
            valid_o = 1'b1;
            if (ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One segment of the ripple: this segment's operand bits plus the carry
   // left behind by the previous segment.
   always_comb begin
      seg_sum = {1'b0, s_q[cnt_q*SEG +: SEG]}
              + {1'b0, cy_q[cnt_q*SEG +: SEG]}
              + {{SEG{1'b0}}, c_q};
   end

   // Operand capture on accept, then one resolved segment per BUSY cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_q    <= '0;
         cy_q   <= '0;
         res_q  <= '0;
         cnt_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
      end else if (accept) begin
         s_q   <= sum_i;
         cy_q  <= carry_i;
         c_q   <= 1'b0;
         cnt_q <= '0;
      end else if (state == BUSY) begin
         res_q[cnt_q*SEG +: SEG] <= seg_sum[SEG-1:0];
         c_q                     <= seg_sum[SEG];
         if (cnt_q == LAST) begin
            cout_q <= seg_sum[SEG];
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign result_o = res_q;
   assign cout_o   = cout_q;

endmodule
